piso_serializer: RTL and testbench

//   Parallel-in serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake
//   and shifts it out one bit per clk on ser_out, with a framing valid and a last-bit marker.
//   It drives the serial D input of the flip-flop/shift-register receive chains in this lab.

---
 rtl/piso_serializer.sv | 77 +++++++
 tb/tb_piso_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready input and framed serial output
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The last-bit cycle doubles as an accept slot so frames stream without gaps.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    at_last   = (state == SHIFT) && (cnt == LAST_CNT);
    in_ready  = reset && ((state == IDLE) || at_last);
    accept    = in_valid && in_ready;
    if (accept) begin
      state_nxt = SHIFT;
      shreg_nxt = in_data;
      cnt_nxt   = '0;
    end else if (state == SHIFT) begin
      if (at_last) begin
        state_nxt = IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end else begin
        if (MSB_FIRST) begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
        end else begin
          shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        end
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Outputs are gated by reset so they read 0 for the whole reset window.
  always_comb begin
    ser_valid = reset && (state == SHIFT);
    ser_last  = ser_valid && (cnt == LAST_CNT);
    ser_out   = reset && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - bench for piso_serializer, MSB-first and LSB-first instances side by side
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic l;
  } sbit_t;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       rdy_m, out_m, val_m, last_m;
  logic       rdy_l, out_l, val_l, last_l;

  sbit_t qm[$];
  sbit_t ql[$];
  logic  last_acc;
  int    pass_cnt;
  int    total_cnt;
  vec_t  tbl[6];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy_m), .in_data(in_data),
    .ser_out(out_m), .ser_valid(val_m), .ser_last(last_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(rdy_l), .in_data(in_data),
    .ser_out(out_l), .ser_valid(val_l), .ser_last(last_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  task automatic timeout_fail(input string name);
    total_cnt++;
    $display("FAIL %s: cycle budget expired at %0t", name, $time);
  endtask

  task automatic check_all();
    logic ev, eo, el;
    ev = (qm.size() > 0);
    eo = ev ? qm[0].b : 1'b0;
    el = ev ? qm[0].l : 1'b0;
    chk("m_ready", rdy_m, rst && (qm.size() <= 1));
    chk("m_valid", val_m, ev);
    chk("m_out",   out_m, eo);
    chk("m_last",  last_m, el);
    ev = (ql.size() > 0);
    eo = ev ? ql[0].b : 1'b0;
    el = ev ? ql[0].l : 1'b0;
    chk("l_ready", rdy_l, rst && (ql.size() <= 1));
    chk("l_valid", val_l, ev);
    chk("l_out",   out_l, eo);
    chk("l_last",  last_l, el);
  endtask

  // em/el list the expected serial bits first-sent in bit 7.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [7:0] em,
                       input logic [7:0] el, input logic r);
    logic acc;
    in_valid = v;
    in_data  = d;
    rst      = r;
    acc = r && v && (qm.size() <= 1);
    if (qm.size() > 0) void'(qm.pop_front());
    if (ql.size() > 0) void'(ql.pop_front());
    if (!r) begin
      qm.delete();
      ql.delete();
    end
    if (acc) begin
      for (int k = 0; k < 8; k++) begin
        qm.push_back('{b: em[7-k], l: (k == 7)});
        ql.push_back('{b: el[7-k], l: (k == 7)});
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, 8'($urandom), 8'h00, 8'h00, r);
  endtask

  task automatic send_word(input logic [7:0] d, input logic [7:0] em, input logic [7:0] el);
    int n;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin
      cycle(1'b1, d, em, el, 1'b1);
      n++;
    end
    if (!last_acc) timeout_fail("send_word");
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (qm.size() > 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    if (qm.size() > 0) timeout_fail("drain");
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;

    tbl[0] = '{data: 8'hA5, exp_m: 8'hA5, exp_l: 8'hA5};
    tbl[1] = '{data: 8'h01, exp_m: 8'h01, exp_l: 8'h80};
    tbl[2] = '{data: 8'h12, exp_m: 8'h12, exp_l: 8'h48};
    tbl[3] = '{data: 8'hE8, exp_m: 8'hE8, exp_l: 8'h17};
    tbl[4] = '{data: 8'hF0, exp_m: 8'hF0, exp_l: 8'h0F};
    tbl[5] = '{data: 8'h80, exp_m: 8'h80, exp_l: 8'h01};

    // reset held with a word offered: nothing accepted, outputs quiet
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    idle(1'b1);

    // isolated frames from the table, each followed by a return to IDLE
    for (int i = 0; i < 6; i++) begin
      send_word(tbl[i].data, tbl[i].exp_m, tbl[i].exp_l);
      drain();
      idle(1'b1);
    end

    // back-to-back frames: second word held off until the last-bit cycle
    send_word(8'hF0, 8'hF0, 8'h0F);
    send_word(8'h0F, 8'h0F, 8'hF0);
    drain();

    // reset after the third bit aborts the frame; next word starts clean
    send_word(8'hFF, 8'hFF, 8'hFF);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);
    send_word(8'h81, 8'h81, 8'h81);
    drain();

    // garbage on in_data without valid, then 3C offered at cnt=3 of a 00 frame
    send_word(8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) idle(1'b1);
    send_word(8'h3C, 8'h3C, 8'h3C);
    drain();
    idle(1'b1);

    // reset wins over an accept offered at the last-bit edge
    send_word(8'hAA, 8'hAA, 8'h55);
    for (int i = 0; i < 7; i++) idle(1'b1);
    cycle(1'b1, 8'h77, 8'h77, 8'hEE, 1'b0);
    idle(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
